// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU run controller (cpu_run_ctrl) and its
// register-dump engine (cpu_ctrl_dump).
//   - ctrl_state_e : session state encoding (IDLE, LOAD, HOLD, RUN, DUMP, DONE)
//   - dump_state_e : dump engine phase encoding
//   - DEF_*        : default parameter values and the widths derived from them
//   - width_of()   : clog2 with a floor of one bit, for counter/address widths
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DUMP,
        S_DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_READ,   // rf_raddr presented, read data arrives next cycle
        D_SHOW    // dump word offered on the valid/ready port
    } dump_state_e;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_INST_W         = 32;
    localparam int DEF_IMEM_DEPTH     = 64;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_REG_W          = 32;
    localparam int DEF_RST_CYCLES     = 1;
    localparam int DEF_MAX_RUN_CYCLES = 110;

    localparam int DEF_IA_W = width_of(DEF_IMEM_DEPTH);
    localparam int DEF_RA_W = width_of(DEF_NUM_REGS);
    localparam int DEF_CW   = width_of(DEF_MAX_RUN_CYCLES + 1);

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Host-facing streams of the CPU run controller.
//   Program stream (host -> controller): prog_valid, prog_data, prog_last,
//                                        prog_ready
//   Dump stream (controller -> host):    dump_valid, dump_idx, dump_data,
//                                        dump_ready
// Modports:
//   master : host side (drives the program stream, consumes the dump stream)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int RA_W   = DEF_RA_W,
    parameter int REG_W  = DEF_REG_W
) ();

    logic              prog_valid;
    logic [INST_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;

    logic              dump_valid;
    logic [RA_W-1:0]   dump_idx;
    logic [REG_W-1:0]  dump_data;
    logic              dump_ready;

    modport master (
        output prog_valid, prog_data, prog_last,
        input  prog_ready,
        input  dump_valid, dump_idx, dump_data,
        output dump_ready
    );

    modport slave (
        input  prog_valid, prog_data, prog_last,
        output prog_ready,
        output dump_valid, dump_idx, dump_data,
        input  dump_ready
    );

endinterface

// File: rtl/cpu_ctrl_dump.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_dump
// Register-file dump engine. On a kick it walks idx = 0..NUM_REGS-1, presents
// each index on the debug read port, and offers the returned value on a
// valid/ready port one cycle later. Two cycles per word when never stalled.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   kick            start a dump from index 0 (one-cycle pulse)
//   rf_raddr        register-file debug read address (= idx)
//   rf_rdata        read data, valid one cycle after rf_raddr
//   dump_valid/idx/data, dump_ready   output word handshake
//   finished        pulse on the handshake of the last register
// ---------------------------------------------------------------------------
module cpu_ctrl_dump
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int RA_W     = width_of(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kick,
    output logic [RA_W-1:0]  rf_raddr,
    input  logic [REG_W-1:0] rf_rdata,
    output logic             dump_valid,
    output logic [RA_W-1:0]  dump_idx,
    output logic [REG_W-1:0] dump_data,
    input  logic             dump_ready,
    output logic             finished
);

    localparam logic [RA_W-1:0] IDX_LAST = RA_W'(NUM_REGS - 1);

    dump_state_e      dstate, dstate_nxt;
    logic [RA_W-1:0]  idx;
    logic             first;   // first cycle of D_SHOW: rf_rdata is the fresh read
    logic [REG_W-1:0] hold_q;  // word captured on the first D_SHOW cycle

    // idx is a register and only moves on a handshake, so both the read
    // address and the reported index stay put while the consumer stalls.
    assign rf_raddr = idx;
    assign dump_idx = idx;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        dstate_nxt = dstate;
        dump_valid = (dstate == D_SHOW);
        dump_data  = first ? rf_rdata : hold_q;
        finished   = 1'b0;
        case (dstate)
            D_IDLE: if (kick) dstate_nxt = D_READ;
            D_READ: dstate_nxt = D_SHOW;
            D_SHOW: begin
                if (dump_ready) begin
                    if (idx == IDX_LAST) begin
                        finished   = 1'b1;
                        dstate_nxt = D_IDLE;
                    end else begin
                        dstate_nxt = D_READ;
                    end
                end
            end
            default: dstate_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            dstate <= D_IDLE;
            idx    <= '0;
            first  <= 1'b0;
            hold_q <= '0;
        end else begin
            dstate <= dstate_nxt;
            first  <= (dstate == D_READ);
            // Freeze the presented word so a stall never depends on the
            // register file holding its output.
            if (dstate == D_SHOW) hold_q <= dump_data;
            if (kick) begin
                idx <= '0;
            end else if (dstate == D_SHOW && dump_ready) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the single-cycle CPU: streams a program into instruction
// memory, holds the CPU in reset for RST_CYCLES, runs it for MAX_RUN_CYCLES
// (or until halt), then streams the register file out.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse, accepted in IDLE and DONE
//   host          program-in / dump-out streams (cpu_run_ctrl_if.slave)
//   imem_we/addr/wdata   instruction-memory write port (registered)
//   cpu_rst       CPU reset, low only during RUN
//   halt_in       CPU halt indication
//   rf_raddr, rf_rdata   register-file debug read port
//   busy, done, timeout, load_err   session status
// Configuration:
//   HALT_DETECT_EN  defined: halt_in during RUN ends the run early (halt wins
//                   over the cycle limit, timeout stays 0).
//                   undefined: halt_in is ignored, the run always lasts
//                   MAX_RUN_CYCLES.
// ---------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int INST_W         = DEF_INST_W,
    parameter int IMEM_DEPTH     = DEF_IMEM_DEPTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int REG_W          = DEF_REG_W,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES,
    localparam int IA_W          = width_of(IMEM_DEPTH),
    localparam int RA_W          = width_of(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    cpu_run_ctrl_if.slave     host,
    output logic              imem_we,
    output logic [IA_W-1:0]   imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic              halt_in,
    output logic [RA_W-1:0]   rf_raddr,
    input  logic [REG_W-1:0]  rf_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_err
);

    localparam int CW = width_of(MAX_RUN_CYCLES + 1);
    localparam int HW = width_of(RST_CYCLES + 1);

    localparam logic [IA_W-1:0] LAST_ADDR = IA_W'(IMEM_DEPTH - 1);
    localparam logic [CW-1:0]   RUN_LAST  = CW'(MAX_RUN_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);

    ctrl_state_e     state, state_nxt;
    logic [IA_W-1:0] ptr;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   run_cnt;
    logic            accept;
    logic            halt_hit;
    logic            run_limit;
    logic            session_go;
    logic            dump_kick;
    logic            dump_finished;

`ifdef HALT_DETECT_EN
    assign halt_hit = (state == S_RUN) && halt_in;
`else
    logic unused_halt_in;
    assign unused_halt_in = halt_in;
    assign halt_hit       = 1'b0;
`endif

    assign accept     = (state == S_LOAD) && host.prog_valid;
    assign run_limit  = (state == S_RUN) && (run_cnt == RUN_LAST);
    assign session_go = ((state == S_IDLE) || (state == S_DONE)) && start;

    // Next state and the state-decoded outputs.
    always_comb begin
        state_nxt       = state;
        host.prog_ready = (state == S_LOAD);
        cpu_rst         = (state != S_RUN);
        busy            = (state != S_IDLE) && (state != S_DONE);
        done            = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                // The last slot ends the load even without prog_last.
                if (accept && (host.prog_last || ptr == LAST_ADDR))
                    state_nxt = S_HOLD;
            end
            S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:  if (halt_hit || run_limit) state_nxt = S_DUMP;
            S_DUMP: if (dump_finished) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Kick the dump engine on the RUN->DUMP edge so it presents index 0 in
    // the first DUMP cycle.
    assign dump_kick = (state == S_RUN) && (state_nxt == S_DUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            run_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            timeout    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= host.prog_data;
                if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
                if (ptr == LAST_ADDR && !host.prog_last) load_err <= 1'b1;
            end
            if (session_go) begin
                ptr      <= '0;
                timeout  <= 1'b0;
                load_err <= 1'b0;
            end
            // Counters run only while staying in their state, so they restart
            // from 0 on every entry and never exceed their terminal value.
            hold_cnt <= (state == S_HOLD && state_nxt == S_HOLD) ? hold_cnt + 1'b1 : '0;
            run_cnt  <= (state == S_RUN  && state_nxt == S_RUN)  ? run_cnt + 1'b1  : '0;
            if (run_limit && !halt_hit) timeout <= 1'b1;
        end
    end

    cpu_ctrl_dump #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .RA_W     (RA_W)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .kick       (dump_kick),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump_valid (host.dump_valid),
        .dump_idx   (host.dump_idx),
        .dump_data  (host.dump_data),
        .dump_ready (host.dump_ready),
        .finished   (dump_finished)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. u_a uses the default parameters; u_b uses
// IMEM_DEPTH=8 for the truncated-load case. Each DUT has a register-file
// model returning R[i] = 3*i one cycle after the read address.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

`ifdef HALT_DETECT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] word_of(input int k);
        return 32'hC0DE_0000 + 32'(k * 7);
    endfunction

    // ---------------- DUT A: default parameters ----------------
    cpu_run_ctrl_if #(.INST_W(32), .RA_W(DEF_RA_W), .REG_W(32)) a_bus ();
    logic        a_start, a_halt, a_imem_we, a_cpu_rst;
    logic [5:0]  a_imem_addr;
    logic [31:0] a_imem_wdata, a_rf_rdata;
    logic [4:0]  a_rf_raddr;
    logic        a_busy, a_done, a_timeout, a_load_err;

    cpu_run_ctrl u_a (
        .clk(clk), .rst(rst), .start(a_start), .host(a_bus),
        .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
        .cpu_rst(a_cpu_rst), .halt_in(a_halt),
        .rf_raddr(a_rf_raddr), .rf_rdata(a_rf_rdata),
        .busy(a_busy), .done(a_done), .timeout(a_timeout), .load_err(a_load_err)
    );

    always @(posedge clk) a_rf_rdata <= 32'(a_rf_raddr) * 32'd3;

    // ---------------- DUT B: 8-word instruction memory ----------------
    cpu_run_ctrl_if #(.INST_W(32), .RA_W(DEF_RA_W), .REG_W(32)) b_bus ();
    logic        b_start, b_imem_we, b_cpu_rst;
    logic [2:0]  b_imem_addr;
    logic [31:0] b_imem_wdata, b_rf_rdata;
    logic [4:0]  b_rf_raddr;
    logic        b_busy, b_done, b_timeout, b_load_err;

    cpu_run_ctrl #(.IMEM_DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .host(b_bus),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .cpu_rst(b_cpu_rst), .halt_in(1'b0),
        .rf_raddr(b_rf_raddr), .rf_rdata(b_rf_rdata),
        .busy(b_busy), .done(b_done), .timeout(b_timeout), .load_err(b_load_err)
    );

    always @(posedge clk) b_rf_rdata <= 32'(b_rf_raddr) * 32'd3;

    // ---------------- helpers for DUT A ----------------
    task automatic a_start_session();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("start_busy",       a_busy, 1);
        check("start_prog_ready", a_bus.prog_ready, 1);
        check("start_timeout_clr", a_timeout, 0);
        check("start_load_err_clr", a_load_err, 0);
        check("start_done_clr",   a_done, 0);
    endtask

    // Continuous prog_valid, prog_last on word n-1; returns in the first HOLD cycle.
    task automatic a_load(input int n);
        for (int k = 0; k < n; k++) begin
            a_bus.prog_valid = 1'b1;
            a_bus.prog_data  = word_of(k);
            a_bus.prog_last  = (k == n - 1);
            @(negedge clk);
            check("imem_we",    a_imem_we, 1);
            check("imem_addr",  a_imem_addr, k);
            check("imem_wdata", a_imem_wdata, word_of(k));
        end
        a_bus.prog_valid = 1'b0;
        a_bus.prog_last  = 1'b0;
        check("load_err_clean",   a_load_err, 0);
        check("prog_ready_hold",  a_bus.prog_ready, 0);
        check("cpu_rst_hold",     a_cpu_rst, 1);
    endtask

    // Counts HOLD cycles (cpu_rst=1) then RUN cycles (cpu_rst=0); returns in
    // the first DUMP cycle. halt_in is pulsed during run cycle halt_at.
    task automatic a_run(input int halt_at, output int hold, output int run);
        bit ended;
        ended = 1'b0;
        hold  = 0;
        run   = 0;
        for (int c = 0; c < 400 && !ended; c++) begin
            if (a_cpu_rst) begin
                if (run > 0) ended = 1'b1;
                else hold++;
            end else begin
                a_halt = (run == halt_at);
                run++;
            end
            if (!ended) @(negedge clk);
        end
        a_halt = 1'b0;
        check("run_bounded", ended, 1);
    endtask

    // Drains the dump; checks order, values and stability under stalls.
    task automatic a_dump(input bit rand_ready, output int cnt);
        bit          ended, stalled;
        logic [4:0]  s_idx;
        logic [31:0] s_data;
        ended   = 1'b0;
        stalled = 1'b0;
        s_idx   = '0;
        s_data  = '0;
        cnt     = 0;
        check("dump_first_cycle_invalid", a_bus.dump_valid, 0);
        for (int c = 0; c < 600 && !ended; c++) begin
            a_bus.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_done) begin
                ended = 1'b1;
            end else if (a_bus.dump_valid) begin
                if (stalled) begin
                    check("stall_idx_stable",  a_bus.dump_idx, s_idx);
                    check("stall_data_stable", a_bus.dump_data, s_data);
                end
                if (a_bus.dump_ready) begin
                    check("dump_idx",  a_bus.dump_idx, cnt);
                    check("dump_data", a_bus.dump_data, 32'(cnt * 3));
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_idx   = a_bus.dump_idx;
                    s_data  = a_bus.dump_data;
                end
            end
            if (!ended) @(negedge clk);
        end
        a_bus.dump_ready = 1'b0;
        check("dump_bounded",     ended, 1);
        check("dump_count",       cnt, 32);
        check("done_after_dump",  a_done, 1);
        check("busy_after_dump",  a_busy, 0);
        check("dump_valid_done",  a_bus.dump_valid, 0);
        check("cpu_rst_done",     a_cpu_rst, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, "_cpu_rst"},    a_cpu_rst, 1);
        check({tag, "_busy"},       a_busy, 0);
        check({tag, "_done"},       a_done, 0);
        check({tag, "_dump_valid"}, a_bus.dump_valid, 0);
        check({tag, "_prog_ready"}, a_bus.prog_ready, 0);
        check({tag, "_timeout"},    a_timeout, 0);
    endtask

    initial begin
        int hold, run, cnt, writes;

        rst = 1'b1;
        a_start = 1'b0; a_halt = 1'b0;
        a_bus.prog_valid = 1'b0; a_bus.prog_data = '0; a_bus.prog_last = 1'b0;
        a_bus.dump_ready = 1'b0;
        b_start = 1'b0;
        b_bus.prog_valid = 1'b0; b_bus.prog_data = '0; b_bus.prog_last = 1'b0;
        b_bus.dump_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_a_idle("reset");
        check("reset_imem_we",  a_imem_we, 0);
        check("reset_load_err", a_load_err, 0);
        check("reset_rf_raddr", a_rf_raddr, 0);
        check("reset_dump_data", a_bus.dump_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start_busy", a_busy, 0);

        // Session 1: 5-word load, full run, dump with ready held high
        a_start_session();
        a_load(5);
        a_run(-1, hold, run);
        check("s1_imem_we_dropped", a_imem_we, 0);
        check("s1_hold_cycles", hold, 1);
        check("s1_run_cycles",  run, 110);
        check("s1_timeout",     a_timeout, 1);
        a_dump(1'b0, cnt);

        // Session 2 from DONE: timeout must clear, dump under random stalls
        a_start_session();
        a_load(1);
        a_run(-1, hold, run);
        check("s2_run_cycles", run, 110);
        a_dump(1'b1, cnt);

        // Truncated load on the 8-word instance
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        writes = 0;
        for (int k = 0; k < 10; k++) begin
            b_bus.prog_valid = 1'b1;
            b_bus.prog_data  = word_of(k);
            b_bus.prog_last  = 1'b0;
            @(negedge clk);
            if (b_imem_we) begin
                check("b_imem_addr",  b_imem_addr, writes);
                check("b_imem_wdata", b_imem_wdata, word_of(writes));
                writes++;
            end
            if (k == 6) begin
                check("b_ready_before_last", b_bus.prog_ready, 1);
                check("b_err_before_last",   b_load_err, 0);
            end
            if (k == 7) begin
                check("b_ready_after_8th", b_bus.prog_ready, 0);
                check("b_err_after_8th",   b_load_err, 1);
            end
        end
        b_bus.prog_valid = 1'b0;
        check("b_write_count", writes, 8);
        check("b_load_err",    b_load_err, 1);

        // Reset in mid-RUN
        a_start_session();
        a_load(2);
        repeat (10) @(negedge clk);
        check("midrun_cpu_rst_low", a_cpu_rst, 0);
        pulse_rst();
        check_a_idle("midrun_rst");

        // Reset in mid-DUMP, consumer stalled
        a_start_session();
        a_load(2);
        a_run(-1, hold, run);
        a_bus.dump_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("middump_valid", a_bus.dump_valid, 1);
        check("middump_idx",   a_bus.dump_idx, 0);
        pulse_rst();
        check_a_idle("middump_rst");

        // A fresh session completes after the resets
        a_start_session();
        a_load(3);
        a_run(-1, hold, run);
        check("s3_run_cycles", run, 110);
        check("s3_timeout",    a_timeout, 1);
        a_dump(1'b0, cnt);

        // halt_in during RUN at cycle 20 and at the last cycle (109)
        a_start_session();
        a_load(1);
        a_run(20, hold, run);
        check("halt20_run_cycles", run, HALT_ON ? 21 : 110);
        check("halt20_timeout",    a_timeout, HALT_ON ? 0 : 1);
        a_dump(1'b0, cnt);

        a_start_session();
        a_load(1);
        a_run(109, hold, run);
        check("halt109_run_cycles", run, 110);
        check("halt109_timeout",    a_timeout, HALT_ON ? 0 : 1);
        a_dump(1'b0, cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller for the single-cycle CPU. It performs the load/reset/run/dump sequence in RTL, so bring-up on FPGA and in simulation share one control path.
- Streams a program into instruction memory.
- Holds the CPU in reset for a programmable number of cycles, then runs it for a bounded number of cycles or until halt.
- Streams the register file out over a valid/ready port.
- Sits beside the CPU at top level and drives the CPU reset, the instruction-memory write port and a register-file debug read port.

Parameters:
INST_W, 32, instruction word width
IMEM_DEPTH, 64, instruction memory depth in words; IA_W = clog2(IMEM_DEPTH)
NUM_REGS, 32, register count; RA_W = clog2(NUM_REGS)
REG_W, 32, register width
RST_CYCLES, 1, CPU reset hold length in cycles (at least 1)
MAX_RUN_CYCLES, 110, run limit in cycles; CW = clog2(MAX_RUN_CYCLES+1)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse to begin a session
prog_valid  in  1  program word valid
prog_data  in  INST_W  program word
prog_last  in  1  marks the final program word
prog_ready  out  1  controller accepts a word
imem_we  out  1  instruction-memory write enable
imem_addr  out  IA_W  write address
imem_wdata  out  INST_W  write data
cpu_rst  out  1  CPU reset, active-high
halt_in  in  1  CPU halt indication
rf_raddr  out  RA_W  register-file debug read address
rf_rdata  in  REG_W  read data, valid one cycle after rf_raddr
dump_valid  out  1  dump word valid
dump_idx  out  RA_W  register index of dump word
dump_data  out  REG_W  register value
dump_ready  in  1  consumer accepts dump word
busy  out  1  session in progress
done  out  1  session complete (sticky until next start or rst)
timeout  out  1  run ended on MAX_RUN_CYCLES
load_err  out  1  program truncated at IMEM_DEPTH

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-session: state IDLE.
  - All outputs 0 except cpu_rst=1.
  - Internal counters 0.
- IDLE: start → LOAD next cycle; busy=1; done, timeout and load_err cleared. start is ignored in every state except IDLE and DONE.
- LOAD:
  - prog_ready=1.
  - Accept on prog_valid & prog_ready: next cycle imem_we=1, imem_addr=ptr, imem_wdata=word; ptr increments.
  - imem_we is a single-cycle pulse per accepted word; back-to-back accepts are allowed.
  - Accepted word with prog_last → HOLD.
  - Accepted word at ptr=IMEM_DEPTH-1 without prog_last: set load_err=1 and go to HOLD; prog_ready=0 from that next cycle.
- HOLD: cpu_rst=1 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - cpu_rst=0; run counter starts at 0 on entry and increments every cycle.
  - When the counter reaches MAX_RUN_CYCLES-1 (the CPU has had exactly MAX_RUN_CYCLES unreset cycles): timeout=1, → DUMP.
  - cpu_rst returns to 1 in the first cycle of DUMP and stays 1 until the next RUN.
- DUMP:
  - idx counts 0..NUM_REGS-1; rf_raddr=idx.
  - dump_valid asserts one cycle after rf_raddr is presented.
  - dump_idx and dump_data are registered and held stable while dump_valid & !dump_ready.
  - On a handshake, idx advances. Throughput: one word per 2 cycles minimum; prefetch is not required.
  - Handshake at idx=NUM_REGS-1 → DONE.
- DONE: done=1, busy=0; start → LOAD, same as from IDLE.
- Width rules: ptr wraps never (bounded by load_err); all counters are unsigned and saturate by construction of the state transitions.

Optional Feature:
Macro HALT_DETECT_EN.
- Defined:
  - halt_in=1 during RUN → DUMP next cycle, timeout stays 0.
  - If halt_in and the cycle limit occur in the same cycle, halt wins and timeout=0.
  - halt_in is ignored outside RUN.
- Undefined: halt_in is unused and the run always lasts MAX_RUN_CYCLES.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding enum: IDLE, LOAD, HOLD, RUN, DUMP, DONE;
  - the clog2-derived width constants.
- One natural sub-module, cpu_ctrl_dump: the register-file read/present/handshake engine with its index counter. The FSM, load path and counters stay in the top module.

Test Plan:
- Load 5 words (last on the 5th) with continuous prog_valid → imem writes to addr 0..4 on consecutive cycles; load_err=0; cpu_rst=1 for RST_CYCLES=1, then 0 for exactly 110 cycles; timeout=1.
- Dump with dump_ready held 1 → 32 words with dump_idx 0..31 matching an rf model preloaded with R[i]=3*i; done=1 and busy=0 after idx 31.
- Dump with dump_ready toggled randomly → dump_data stable while stalled; no index skipped or repeated.
- IMEM_DEPTH=8, stream 10 words with no last → only addr 0..7 written; load_err=1; prog_ready=0 after the 8th accept.
- HALT_DETECT_EN defined, halt_in pulsed at run cycle 20 → DUMP entered the next cycle; timeout=0. halt_in at cycle 109 → timeout=0.
- rst asserted in mid-RUN and in mid-DUMP → next cycle IDLE, cpu_rst=1, dump_valid=0, done=0; a new start completes a full session.
